fxp_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined fixed-point multiplier (`pipe_FixedPointMul`, instantiated outside this block) among `NREQ` requesters. It grants at most one operand pair per cycle, drives the multiplier inputs from a register stage, and tracks each issued operation through a tag delay line matched to the multiplier latency. Each result, with its overflow flags, returns to the requester that issued it. It sits between the requesting datapath engines and the shared multiplier.

---
 rtl/fxp_mul_arbiter_if.sv | 27 ++
 rtl/fxp_mul_arbiter.sv | 130 +++++++++++++
 tb/tb_fxp_mul_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_mul_arbiter_if.sv
// Requester-side bundle of the shared multiplier arbiter: operand requests in,
// per-requester grant and one-hot result strobe out.
interface fxp_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WA   = 16,
    parameter int unsigned WB   = 16,
    parameter int unsigned WO   = 18
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*WA-1:0] req_a;
    logic [NREQ*WB-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [WO-1:0]      rsp_data;
    logic               rsp_upflow;
    logic               rsp_downflow;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, rsp_upflow, rsp_downflow
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, rsp_upflow, rsp_downflow
    );
endinterface

// File: rtl/fxp_mul_arbiter.sv
// Round-robin arbiter sharing one free-running pipelined fixed-point multiplier;
// a tag delay line matched to the multiplier latency routes each result home.
module fxp_mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIIA    = 8,
    parameter int unsigned WIFA    = 8,
    parameter int unsigned WIIB    = 8,
    parameter int unsigned WIFB    = 8,
    parameter int unsigned WOI     = 12,
    parameter int unsigned WOF     = 6,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hold,
    fxp_mul_arbiter_if.slave                 bus,
    output logic [WIIA+WIFA-1:0]             mul_ina,
    output logic [WIIB+WIFB-1:0]             mul_inb,
    input  logic [WOI+WOF-1:0]               mul_out,
    input  logic                             mul_upflow,
    input  logic                             mul_downflow,
    output logic [$clog2(MUL_LAT+3)-1:0]     inflight,
    output logic                             idle
);
    localparam int unsigned WA = WIIA + WIFA;
    localparam int unsigned WB = WIIB + WIFB;
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW = $clog2(MUL_LAT + 3);

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] id;
    } tag_t;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_c;
    logic            found_c;
    logic            xfer_c;
    logic [NREQ-1:0] ready_c;
    logic [IW-1:0]   inflight_nxt_c;
    logic [WA-1:0]   a_arr [NREQ];
    logic [WB-1:0]   b_arr [NREQ];
    tag_t            tag   [MUL_LAT+1];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.req_a[g*WA +: WA];
        assign b_arr[g] = bus.req_b[g*WB +: WB];
    end

    // First valid requester at or after ptr, wrapping
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = 32'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found_c && bus.req_valid[PW'(idx)]) begin
                found_c = 1'b1;
                grant_c = PW'(idx);
            end
        end
    end

    assign xfer_c = found_c & ~hold;

    always_comb begin
        ready_c = '0;
        if (xfer_c) ready_c[grant_c] = 1'b1;
    end

    assign bus.req_ready = ready_c;

    // Issue register, pointer and tag delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            mul_ina <= '0;
            mul_inb <= '0;
            for (int j = 0; j <= int'(MUL_LAT); j++) tag[j] <= '0;
        end else begin
            tag[0] <= '{vld: xfer_c, id: grant_c};
            for (int j = 1; j <= int'(MUL_LAT); j++) tag[j] <= tag[j-1];
            if (xfer_c) begin
                mul_ina <= a_arr[grant_c];
                mul_inb <= b_arr[grant_c];
                ptr     <= (grant_c == PW'(NREQ - 1)) ? '0 : grant_c + PW'(1);
            end else begin
                mul_ina <= '0;
                mul_inb <= '0;
            end
        end
    end

    // Response register: data outputs keep their last value between results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_upflow   <= 1'b0;
            bus.rsp_downflow <= 1'b0;
        end else if (tag[MUL_LAT].vld) begin
            bus.rsp_valid    <= NREQ'(1) << tag[MUL_LAT].id;
            bus.rsp_data     <= mul_out;
            bus.rsp_upflow   <= mul_upflow;
            bus.rsp_downflow <= mul_downflow;
        end else begin
            bus.rsp_valid    <= '0;
        end
    end

    always_comb begin
        inflight_nxt_c = inflight;
        case ({xfer_c, |bus.rsp_valid})
            2'b10:   inflight_nxt_c = inflight + IW'(1);
            2'b01:   inflight_nxt_c = inflight - IW'(1);
            default: inflight_nxt_c = inflight;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            idle     <= 1'b1;
        end else begin
            inflight <= inflight_nxt_c;
            idle     <= (inflight_nxt_c == '0);
        end
    end
endmodule

// File: tb/tb_fxp_mul_arbiter.sv
// Directed bench for fxp_mul_arbiter with a behavioural 4-stage multiplier
// (Q8.8 x Q8.8 -> Q12.6, truncating, saturating) standing in for pipe_FixedPointMul.
module tb_fxp_mul_arbiter;
    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [15:0] mul_ina, mul_inb;
    logic [17:0] mul_out;
    logic        mul_upflow, mul_downflow;
    logic [2:0]  inflight;
    logic        idle;

    fxp_mul_arbiter_if #(.NREQ(4), .WA(16), .WB(16), .WO(18)) bus ();

    fxp_mul_arbiter dut (
        .clk(clk), .rst(rst), .hold(hold), .bus(bus),
        .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_out(mul_out), .mul_upflow(mul_upflow), .mul_downflow(mul_downflow),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [17:0] d;
        logic        u;
        logic        dn;
    } mres_t;

    function automatic mres_t mul_model(input logic [15:0] a, input logic [15:0] b);
        longint p, s;
        mres_t  r;
        p = longint'($signed(a)) * longint'($signed(b));
        s = p >>> 10;
        if (s > 131071)       r = '{d: 18'h1FFFF, u: 1'b1, dn: 1'b0};
        else if (s < -131072) r = '{d: 18'h20000, u: 1'b0, dn: 1'b1};
        else                  r = '{d: 18'(s),    u: 1'b0, dn: 1'b0};
        return r;
    endfunction

    mres_t mp [MUL_LAT];
    always @(posedge clk) begin
        mp[0] <= mul_model(mul_ina, mul_inb);
        for (int j = 1; j < MUL_LAT; j++) mp[j] <= mp[j-1];
    end
    assign mul_out      = mp[MUL_LAT-1].d;
    assign mul_upflow   = mp[MUL_LAT-1].u;
    assign mul_downflow = mp[MUL_LAT-1].dn;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] oh(input int id);
        return 4'(1) << id;
    endfunction

    typedef struct {
        int          id;
        logic [17:0] d;
        logic        u;
        logic        dn;
    } rsp_t;

    rsp_t expq[$];
    rsp_t mr;
    bit   mon_en = 1'b0;

    // Response scoreboard: strobes must match issue order, id and payload
    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid != 4'b0) begin
            if (expq.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
                mr = expq.pop_front();
                check("rsp_id",   32'(bus.rsp_valid),    32'(oh(mr.id)));
                check("rsp_data", 32'(bus.rsp_data),     32'(mr.d));
                check("rsp_up",   32'(bus.rsp_upflow),   32'(mr.u));
                check("rsp_down", 32'(bus.rsp_downflow), 32'(mr.dn));
            end
        end
    end

    task automatic push_exp(input int id, input logic [17:0] d, input logic u, input logic dn);
        rsp_t r;
        r.id = id; r.d = d; r.u = u; r.dn = dn;
        expq.push_back(r);
    endtask

    task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[id*16 +: 16] = a;
        bus.req_b[id*16 +: 16] = b;
    endtask

    // Requester i multiplies (i+1).0 by 1.0, giving (i+1)<<6 in Q12.6
    task automatic default_ops();
        for (int i = 0; i < 4; i++) set_ops(i, 16'((i + 1) << 8), 16'h0100);
    endtask

    // Called at a negedge with inputs set; expects this cycle's grant to go to id
    task automatic grant_step(input int id);
        #1;
        check("grant", 32'(bus.req_ready), 32'(oh(id)));
        push_exp(id, 18'((id + 1) << 6), 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(idle), 32'h1);
    endtask

    // Observe the pointer through the combinational grant without letting a transfer happen
    task automatic probe_ptr(input int exp_ptr);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        check("ptr_probe", 32'(bus.req_ready), 32'(oh(exp_ptr)));
        bus.req_valid = 4'b0000;
        #1;
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [17:0] d;
        logic        u;
        logic        dn;
    } vec_t;

    vec_t vt [4];

    task automatic single_op(input vec_t v);
        int  t0;
        bit  got;
        @(negedge clk);
        set_ops(v.id, v.a, v.b);
        bus.req_valid = oh(v.id);
        #1;
        check("single_ready", 32'(bus.req_ready), 32'(oh(v.id)));
        push_exp(v.id, v.d, v.u, v.dn);
        t0 = cyc;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        check("issue_a", 32'(mul_ina), 32'(v.a));
        check("issue_b", 32'(mul_inb), 32'(v.b));
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            if (bus.rsp_valid != 4'b0) begin
                got = 1'b1;
                check("latency", 32'(cyc - t0), 32'd6);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("rsp_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int n_rsp, last_rsp, idle_cyc, leak;

        vt[0] = '{id: 2, a: 16'h0180, b: 16'h0200, d: 18'h000C0, u: 1'b0, dn: 1'b0};
        vt[1] = '{id: 1, a: 16'h7F00, b: 16'h7F00, d: 18'h1FFFF, u: 1'b1, dn: 1'b0};
        vt[2] = '{id: 0, a: 16'hFF00, b: 16'h0280, d: 18'h3FF60, u: 1'b0, dn: 1'b0};
        vt[3] = '{id: 3, a: 16'h8000, b: 16'h7F00, d: 18'h20000, u: 1'b0, dn: 1'b1};

        rst = 1'b0;
        hold = 1'b0;
        bus.req_valid = 4'b0000;
        default_ops();
        repeat (2) @(negedge clk);
        check("rst_mul_ina",   32'(mul_ina),       32'h0);
        check("rst_mul_inb",   32'(mul_inb),       32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("rst_inflight",  32'(inflight),      32'h0);
        check("rst_idle",      32'(idle),          32'h1);
        check("rst_ready",     32'(bus.req_ready), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) single_op(vt[v]);
        wait_idle();
        default_ops();

        // Continuous requests from everyone: ptr is 0 after requester 3 was last served
        @(negedge clk);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            check("inflight_ramp", 32'(inflight), 32'((n < 6) ? n : 6));
            grant_step(n % 4);
        end
        bus.req_valid = 4'b0000;
        wait_idle();

        // Last continuous grant went to 1, so ptr is 2: 3 wins over 1
        @(negedge clk);
        bus.req_valid = 4'b1010;
        grant_step(3);
        bus.req_valid = 4'b0010;
        grant_step(1);
        bus.req_valid = 4'b0000;
        wait_idle();
        probe_ptr(2);

        // Three in flight, then hold blocks grants in the same cycle it rises
        @(negedge clk);
        bus.req_valid = 4'b0111;
        grant_step(2);
        grant_step(0);
        grant_step(1);
        hold = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        check("hold_blocks", 32'(bus.req_ready), 32'h0);
        n_rsp = 0; last_rsp = -1; idle_cyc = -1; leak = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.req_ready != 4'b0) leak++;
            if (bus.rsp_valid != 4'b0) begin
                n_rsp++;
                last_rsp = cyc;
            end
            if (idle && idle_cyc < 0) idle_cyc = cyc;
        end
        check("hold_ready_leak", 32'(leak),     32'h0);
        check("hold_rsp_count",  32'(n_rsp),    32'd3);
        check("hold_idle_cycle", 32'(idle_cyc), 32'(last_rsp + 1));
        hold = 1'b0;
        bus.req_valid = 4'b0000;

        // Reset with four operations in flight discards all of them
        @(negedge clk);
        bus.req_valid = 4'b1111;
        grant_step(2);
        grant_step(3);
        grant_step(0);
        grant_step(1);
        rst = 1'b0;
        expq.delete();
        bus.req_valid = 4'b0000;
        #1;
        check("mid_rst_inflight", 32'(inflight), 32'h0);
        check("mid_rst_idle",     32'(idle),     32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        leak = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 4'b0) leak++;
        end
        check("post_rst_no_rsp",   32'(leak),     32'h0);
        check("post_rst_inflight", 32'(inflight), 32'h0);
        check("post_rst_mul_ina",  32'(mul_ina),  32'h0);
        probe_ptr(0);

        check("exp_queue_empty", 32'(expq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
